// File: rtl/keypad_scan_debounce_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The lowest-low-row helper resolves which of several pressed rows is reported.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      PRESS_DB = 2'd1,
      ACCEPT   = 2'd2,
      HOLD_REL = 2'd3
   } state_t;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEY_W    = 4;

   function automatic logic [1:0] lowest_low(input logic [NUM_ROWS-1:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = NUM_ROWS - 1; i >= 0; i--) begin
         if (rows[i] == 1'b0) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_debounce_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // metastability filter: two back-to-back stages
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with press/release debounce, producing a key code
// and a single-cycle data_available strobe for the downstream load enable.
module keypad_scan_debounce
   import keypad_pkg::*;
#(
   parameter int SCAN_TICKS     = 27000,
   parameter int DEBOUNCE_TICKS = 270000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_ROWS-1:0] rows_n,
   output logic [NUM_COLS-1:0] cols_n,
   output logic [KEY_W-1:0]    key_code,
   output logic                data_available,
   output logic                key_pressed
);

   localparam int MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS);
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);

   logic [NUM_ROWS-1:0] rows_s;
   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [1:0]          col_idx, col_nxt;
   logic [1:0]          row_idx, row_nxt;
   logic [NUM_COLS-1:0] cols_n_nxt;
   logic [KEY_W-1:0]    key_code_nxt;
   logic                data_available_nxt;
   logic                key_pressed_nxt;
   logic                row_high;
   logic                deb_done;

   sync_2ff #(
      .WIDTH   (NUM_ROWS),
      .RST_VAL (4'hF)
   ) u_rows_sync (
      .clk (clk),
      .rst (rst),
      .d   (rows_n),
      .q   (rows_s)
   );

   assign row_high = rows_s[row_idx];
   assign deb_done = (cnt == DEB_LAST);

   // state, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= SCAN;
         cnt            <= '0;
         col_idx        <= 2'd0;
         row_idx        <= 2'd0;
         cols_n         <= 4'b1110;
         key_code       <= 4'h0;
         data_available <= 1'b0;
         key_pressed    <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         col_idx        <= col_nxt;
         row_idx        <= row_nxt;
         cols_n         <= cols_n_nxt;
         key_code       <= key_code_nxt;
         data_available <= data_available_nxt;
         key_pressed    <= key_pressed_nxt;
      end
   end

   // next-state, counter and column/row selection
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      col_nxt   = col_idx;
      row_nxt   = row_idx;
      case (state)
         SCAN: begin
            if (cnt == SCAN_LAST) begin
               cnt_nxt = '0;
               if (rows_s != 4'hF) begin
                  row_nxt   = lowest_low(rows_s);
                  state_nxt = PRESS_DB;
               end else begin
                  col_nxt = col_idx + 2'd1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         PRESS_DB: begin
            if (!row_high) begin
               if (deb_done) begin
                  state_nxt = ACCEPT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else begin
               // bounce: re-scan the same column from the start
               state_nxt = SCAN;
               cnt_nxt   = '0;
            end
         end
         ACCEPT: begin
            state_nxt = HOLD_REL;
            cnt_nxt   = '0;
         end
         HOLD_REL: begin
            if (row_high) begin
               if (deb_done) begin
                  state_nxt = SCAN;
                  cnt_nxt   = '0;
                  col_nxt   = col_idx + 2'd1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else begin
               cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
         end
      endcase
   end

   // next values of the registered outputs
   always_comb begin
      cols_n_nxt         = ~(4'b0001 << col_nxt);
      key_code_nxt       = key_code;
      data_available_nxt = 1'b0;
      key_pressed_nxt    = key_pressed;
      case (state)
         ACCEPT: begin
            key_code_nxt       = {row_idx, col_idx};
            data_available_nxt = 1'b1;
            key_pressed_nxt    = 1'b1;
         end
         HOLD_REL: begin
            if (row_high && deb_done) begin
               key_pressed_nxt = 1'b0;
            end else begin
               key_pressed_nxt = key_pressed;
            end
         end
         default: begin
            key_pressed_nxt = key_pressed;
         end
      endcase
   end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
Scans a 4x4 matrix keypad, debounces press and release, and emits a 4-bit key code with a single-cycle data_available strobe. It sits directly upstream of the enabled data registers. data_available drives their load enable and key_code drives their data input. The block runs entirely in the clk domain (27 MHz board clock). Row inputs are asynchronous and are synchronised internally.

Parameters:
SCAN_TICKS, 27000, clk cycles each column is driven before advancing (1 ms); must be >= 4.
DEBOUNCE_TICKS, 270000, consecutive stable cycles required to accept a press or a release (10 ms); must be >= 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
rows_n  in  4  keypad rows, active-low (pull-ups), asynchronous.
cols_n  out  4  column drive, active-low one-hot.
key_code  out  4  code of the last accepted key = {row_idx[1:0], col_idx[1:0]}; held until the next accepted key.
data_available  out  1  one-cycle pulse when key_code updates.
key_pressed  out  1  high from acceptance until the release is debounced.

Behaviour:
- Reset is synchronous and active-high, sampled on the clk edge. On the edge with rst=1 the block sets:
  - cols_n=4'b1110, col_idx=0, state=SCAN, both counters=0
  - key_code=4'h0, data_available=0, key_pressed=0
  - synchroniser stages=4'hF
- Reset mid-operation aborts any state without a pulse.
- rows_n passes through a 2-FF synchroniser to give rows_s. The FSM sees only rows_s.
- SCAN:
  - tick counter runs 0..SCAN_TICKS-1 with col_idx held.
  - At count SCAN_TICKS-1, rows_s is sampled.
  - If any bit is 0: row_idx = lowest-index low row; go to PRESS_DB with the column kept and the counter cleared.
  - Otherwise col_idx advances (3 wraps to 0), cols_n updates, and the counter clears.
- PRESS_DB:
  - The column stays held.
  - Each cycle rows_s[row_idx]==0 increments the counter.
  - A 1 returns the FSM to SCAN with the same column and counter=0 (bounce rejected; no output change).
  - When the counter reaches DEBOUNCE_TICKS-1 with the row still low, go to ACCEPT.
- ACCEPT (1 cycle):
  - Registered outputs update on leaving ACCEPT: key_code <= {row_idx,col_idx}, data_available <= 1 for exactly one cycle, key_pressed <= 1.
  - Next state: HOLD_REL with counter=0.
- HOLD_REL:
  - The column stays held and data_available=0.
  - rows_s[row_idx]==1 increments the counter; any 0 clears it.
  - At DEBOUNCE_TICKS-1 consecutive highs: key_pressed <= 0, col_idx advances, go to SCAN.
- Held key: exactly one pulse per press, with no auto-repeat.
- Keys pressed in other columns while in PRESS_DB/HOLD_REL are invisible because their column is not driven. They are detected once scanning resumes, if still held.
- Multiple low rows in the scanned column: the lowest row index wins.
- Latency: a clean press is detected within 4*SCAN_TICKS + 2 cycles. The data_available pulse follows detection after DEBOUNCE_TICKS + 1 further cycles.
- Counters are sized $clog2(max(SCAN_TICKS, DEBOUNCE_TICKS)) bits. They never wrap: they are compared with ==, and cleared on every state change.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, PRESS_DB, ACCEPT, HOLD_REL}
  - constants NUM_ROWS=4, NUM_COLS=4, KEY_W=4
- Sub-module sync_2ff: parameterised width and reset value, synchronous active-high rst. It is used for rows_n and is reusable for other async inputs.

Test Plan:
All tests use SCAN_TICKS=4 and DEBOUNCE_TICKS=8. The bench keypad model drives rows_n[r]=0 iff key (r,c) is pressed and cols_n[c]=0.
1. Reset and scan: rst=1 for 3 cycles, then 0 -> outputs at reset values; cols_n sequence 1110,1101,1011,0111,1110 with 4 cycles per column; no data_available.
2. Clean press of key (1,2) held for 60 cycles -> exactly one data_available pulse with key_code=4'h6; key_pressed rises with the pulse and falls 8 cycles after rows_s goes high on release; scanning resumes at column 3.
3. Bounce: key (0,0) low for 5 cycles, then released -> no pulse; key_code keeps its prior value; scanning continues.
4. Release bounce: key (2,1) accepted (code 4'h9), release with 3 high / 2 low / stable high -> key_pressed stays high until 8 consecutive high cycles; still exactly one pulse.
5. Rollover: press (0,0), then (3,3) while (0,0) held; release (0,0) and keep (3,3) -> pulses with codes 4'h0, then 4'hF, in order; no third pulse.
6. Reset mid-PRESS_DB (rst pulsed 1 cycle at debounce count 4) -> no pulse; cols_n=4'b1110 on the following cycle; scanning restarts and the still-held key is accepted later with one pulse.
